regfile_wb_bypass: RTL and testbench

- Receiving end of the writeback interface: consumes the registered `wb_reg`/`write` pair the writeback stage drives each cycle, plus the destination address travelling alongside it.
- Holds the 32x32 architectural register file and two registered read ports for decode, with same-cycle write-to-read bypass.
- Keeps a per-register pending scoreboard: set at issue, cleared at writeback. Decode stalls on it until the producing result arrives.

---
 rtl/regfile_wb_bypass.sv | 89 ++++++++
 tb/tb_regfile_wb_bypass.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_bypass.sv
// Architectural register file with two registered read ports, writeback-to-read
// bypass and a per-register pending scoreboard that stalls decode on outstanding producers.
module regfile_wb_bypass #(
    parameter int unsigned NREG = 32,
    parameter int unsigned DW   = 32,
    parameter int unsigned AW   = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            wb_write,
    input  logic [AW-1:0]   wb_addr,
    input  logic [DW-1:0]   wb_data,
    input  logic            rd_en,
    input  logic [AW-1:0]   rd_addr1,
    input  logic [AW-1:0]   rd_addr2,
    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_dst,
    output logic [DW-1:0]   rd_data1,
    output logic [DW-1:0]   rd_data2,
    output logic            rd_valid,
    output logic            hazard,
    output logic [NREG-1:0] pending
);

    logic [DW-1:0]   regs [NREG];
    logic            wb_hit;
    logic            clr1;
    logic            clr2;
    logic            busy1;
    logic            busy2;
    logic [NREG-1:0] clr_vec;
    logic [NREG-1:0] iss_vec;
    logic [NREG-1:0] pending_next;
    logic [DW-1:0]   next1;
    logic [DW-1:0]   next2;

    // Hazard detection, bypass selection and scoreboard next state
    always_comb begin
        wb_hit = wb_write && (wb_addr != '0);
        clr1   = wb_hit && (wb_addr == rd_addr1);
        clr2   = wb_hit && (wb_addr == rd_addr2);
        busy1  = pending[rd_addr1] && !clr1;
        busy2  = pending[rd_addr2] && !clr2;
        hazard = !rst && rd_en && (busy1 || busy2);

        clr_vec = wb_hit ? (NREG'(1) << wb_addr) : '0;
        iss_vec = (issue_valid && (issue_dst != '0)) ? (NREG'(1) << issue_dst) : '0;
        // A same-edge issue re-arms the bit after the clear: the new producer is outstanding
        pending_next = flush ? '0 : ((pending & ~clr_vec) | iss_vec);

        if (rd_addr1 == '0)
            next1 = '0;
        else if (clr1)
            next1 = wb_data;
        else
            next1 = regs[rd_addr1];

        if (rd_addr2 == '0)
            next2 = '0;
        else if (clr2)
            next2 = wb_data;
        else
            next2 = regs[rd_addr2];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NREG); i++)
                regs[i] <= '0;
            rd_data1 <= '0;
            rd_data2 <= '0;
            rd_valid <= 1'b0;
            pending  <= '0;
        end else begin
            if (wb_hit)
                regs[wb_addr] <= wb_data;
            if (rd_en && !hazard) begin
                rd_data1 <= next1;
                rd_data2 <= next2;
                rd_valid <= 1'b1;
            end else begin
                rd_valid <= 1'b0;
            end
            pending <= pending_next;
        end
    end

endmodule

// File: tb/tb_regfile_wb_bypass.sv
// Bench for regfile_wb_bypass: directed vector table, hand-written reset sequence,
// then randomized traffic checked against an array-based reference model.
module tb_regfile_wb_bypass;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        wb_write;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        rd_en;
    logic [4:0]  rd_addr1;
    logic [4:0]  rd_addr2;
    logic        issue_valid;
    logic [4:0]  issue_dst;
    logic [31:0] rd_data1;
    logic [31:0] rd_data2;
    logic        rd_valid;
    logic        hazard;
    logic [31:0] pending;

    int n_total = 0;
    int n_pass  = 0;

    regfile_wb_bypass dut (
        .clk(clk), .rst(rst), .flush(flush),
        .wb_write(wb_write), .wb_addr(wb_addr), .wb_data(wb_data),
        .rd_en(rd_en), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .issue_valid(issue_valid), .issue_dst(issue_dst),
        .rd_data1(rd_data1), .rd_data2(rd_data2), .rd_valid(rd_valid),
        .hazard(hazard), .pending(pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        fl;
        logic        wbw;
        logic [4:0]  wba;
        logic [31:0] wbd;
        logic        rde;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic        iv;
        logic [4:0]  id;
        logic        ehz;
        logic [31:0] ed1;
        logic [31:0] ed2;
        logic        ev;
        logic [31:0] ep;
    } vec_t;

    vec_t tv[22];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive(input logic fl, input logic wbw, input logic [4:0] wba,
                         input logic [31:0] wbd, input logic rde, input logic [4:0] a1,
                         input logic [4:0] a2, input logic iv, input logic [4:0] id);
        flush = fl; wb_write = wbw; wb_addr = wba; wb_data = wbd;
        rd_en = rde; rd_addr1 = a1; rd_addr2 = a2; issue_valid = iv; issue_dst = id;
    endtask

    function automatic vec_t mk(input logic fl, input logic wbw, input logic [4:0] wba,
                                input logic [31:0] wbd, input logic rde, input logic [4:0] a1,
                                input logic [4:0] a2, input logic iv, input logic [4:0] id,
                                input logic ehz, input logic [31:0] ed1, input logic [31:0] ed2,
                                input logic ev, input logic [31:0] ep);
        vec_t v;
        v.fl = fl; v.wbw = wbw; v.wba = wba; v.wbd = wbd; v.rde = rde; v.a1 = a1; v.a2 = a2;
        v.iv = iv; v.id = id; v.ehz = ehz; v.ed1 = ed1; v.ed2 = ed2; v.ev = ev; v.ep = ep;
        return v;
    endfunction

    // Apply one cycle: hazard sampled mid-cycle, registered outputs just after the edge
    task automatic apply(input vec_t v, input string tag);
        drive(v.fl, v.wbw, v.wba, v.wbd, v.rde, v.a1, v.a2, v.iv, v.id);
        @(negedge clk);
        check({tag, " hazard"}, 32'(hazard), 32'(v.ehz));
        @(posedge clk);
        #1;
        check({tag, " rd_data1"}, rd_data1, v.ed1);
        check({tag, " rd_data2"}, rd_data2, v.ed2);
        check({tag, " rd_valid"}, 32'(rd_valid), 32'(v.ev));
        check({tag, " pending"}, pending, v.ep);
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Reference model state
    logic [31:0] m_regs [32];
    logic [31:0] m_pend;
    logic [31:0] m_d1;
    logic [31:0] m_d2;
    logic        m_v;

    initial begin
        vec_t v;
        logic fl, wbw, rde, iv, m_hz;
        logic [4:0] wba, a1, a2, id;
        logic [31:0] wbd;

        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0);
        rst = 1'b1;
        #3;
        check("por rd_data1", rd_data1, 32'd0);
        check("por pending", pending, 32'd0);
        do_reset();
        check("reset rd_valid", 32'(rd_valid), 32'd0);

        //            fl wbw wba  wbd            rde a1 a2 iv id  hz  d1            d2            v  pend
        tv[0]  = mk(0, 1, 3,  32'hDEADBEEF, 0, 0, 0, 0, 0,  0, 32'h0,        32'h0,        0, 32'h0);
        tv[1]  = mk(0, 0, 0,  32'h0,        1, 3, 0, 0, 0,  0, 32'hDEADBEEF, 32'h0,        1, 32'h0);
        tv[2]  = mk(0, 1, 7,  32'h1,        0, 0, 0, 0, 0,  0, 32'hDEADBEEF, 32'h0,        0, 32'h0);
        tv[3]  = mk(0, 1, 7,  32'h12345678, 1, 7, 3, 0, 0,  0, 32'h12345678, 32'hDEADBEEF, 1, 32'h0);
        tv[4]  = mk(0, 0, 0,  32'h0,        0, 0, 0, 1, 9,  0, 32'h12345678, 32'hDEADBEEF, 0, 32'h200);
        tv[5]  = mk(0, 0, 0,  32'h0,        1, 0, 9, 0, 0,  1, 32'h12345678, 32'hDEADBEEF, 0, 32'h200);
        tv[6]  = mk(0, 0, 0,  32'h0,        1, 0, 9, 0, 0,  1, 32'h12345678, 32'hDEADBEEF, 0, 32'h200);
        tv[7]  = mk(0, 0, 0,  32'h0,        1, 0, 9, 0, 0,  1, 32'h12345678, 32'hDEADBEEF, 0, 32'h200);
        tv[8]  = mk(0, 1, 9,  32'hA5A5A5A5, 1, 0, 9, 0, 0,  0, 32'h0,        32'hA5A5A5A5, 1, 32'h0);
        tv[9]  = mk(0, 0, 0,  32'h0,        0, 0, 0, 1, 4,  0, 32'h0,        32'hA5A5A5A5, 0, 32'h10);
        tv[10] = mk(0, 1, 4,  32'h44444444, 0, 0, 0, 1, 4,  0, 32'h0,        32'hA5A5A5A5, 0, 32'h10);
        tv[11] = mk(1, 0, 0,  32'h0,        0, 0, 0, 0, 0,  0, 32'h0,        32'hA5A5A5A5, 0, 32'h0);
        tv[12] = mk(0, 0, 0,  32'h0,        1, 4, 3, 0, 0,  0, 32'h44444444, 32'hDEADBEEF, 1, 32'h0);
        tv[13] = mk(0, 0, 0,  32'h0,        0, 0, 0, 1, 2,  0, 32'h44444444, 32'hDEADBEEF, 0, 32'h4);
        tv[14] = mk(0, 0, 0,  32'h0,        0, 0, 0, 1, 10, 0, 32'h44444444, 32'hDEADBEEF, 0, 32'h404);
        tv[15] = mk(1, 0, 0,  32'h0,        0, 0, 0, 1, 11, 0, 32'h44444444, 32'hDEADBEEF, 0, 32'h0);
        tv[16] = mk(0, 1, 0,  32'hFFFFFFFF, 1, 0, 0, 0, 0,  0, 32'h0,        32'h0,        1, 32'h0);
        tv[17] = mk(0, 0, 0,  32'h0,        1, 0, 7, 0, 0,  0, 32'h0,        32'h12345678, 1, 32'h0);
        tv[18] = mk(0, 0, 0,  32'h0,        0, 0, 0, 1, 0,  0, 32'h0,        32'h12345678, 0, 32'h0);
        tv[19] = mk(0, 0, 0,  32'h0,        1, 0, 0, 0, 0,  0, 32'h0,        32'h0,        1, 32'h0);
        tv[20] = mk(1, 1, 12, 32'hC0FFEE00, 0, 0, 0, 1, 13, 0, 32'h0,        32'h0,        0, 32'h0);
        tv[21] = mk(0, 0, 0,  32'h0,        1, 12, 13, 0, 0, 0, 32'hC0FFEE00, 32'h0,       1, 32'h0);

        for (int i = 0; i < 22; i++)
            apply(tv[i], $sformatf("vec%0d", i));

        // Asynchronous reset in the middle of a cycle with a stalled read in flight
        apply(mk(0, 0, 0, 32'h0, 0, 0, 0, 1, 5, 0, 32'hC0FFEE00, 32'h0, 0, 32'h20), "pre_rst");
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 5'd12, 1'b0, 5'd0);
        #2;
        check("pre_rst hazard", 32'(hazard), 32'd1);
        rst = 1'b1;
        #1;
        check("async rd_data1", rd_data1, 32'd0);
        check("async rd_data2", rd_data2, 32'd0);
        check("async rd_valid", 32'(rd_valid), 32'd0);
        check("async pending", pending, 32'd0);
        check("async hazard", 32'(hazard), 32'd0);
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        apply(mk(0, 0, 0, 32'h0, 1, 5, 12, 0, 0, 0, 32'h0, 32'h0, 1, 32'h0), "post_rst");

        // Randomized traffic against the reference model
        do_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_pend = 32'd0; m_d1 = 32'd0; m_d2 = 32'd0; m_v = 1'b0;

        for (int cyc = 0; cyc < 400; cyc++) begin
            fl  = ($urandom_range(0, 19) == 0);
            wbw = ($urandom_range(0, 1) == 1);
            wba = 5'($urandom_range(0, 7));
            wbd = $urandom;
            rde = ($urandom_range(0, 3) != 0);
            a1  = 5'($urandom_range(0, 7));
            a2  = 5'($urandom_range(0, 7));
            m_hz = rde && ((m_pend[a1] && !(wbw && wba == a1 && a1 != 0)) ||
                           (m_pend[a2] && !(wbw && wba == a2 && a2 != 0)));
            iv  = !m_hz && ($urandom_range(0, 2) == 0);
            id  = 5'($urandom_range(0, 7));

            drive(fl, wbw, wba, wbd, rde, a1, a2, iv, id);
            @(negedge clk);
            check("rnd hazard", 32'(hazard), 32'(m_hz));
            @(posedge clk);
            #1;

            if (rde && !m_hz) begin
                m_d1 = (a1 == 0) ? 32'd0 : (wbw && wba == a1) ? wbd : m_regs[a1];
                m_d2 = (a2 == 0) ? 32'd0 : (wbw && wba == a2) ? wbd : m_regs[a2];
                m_v  = 1'b1;
            end else begin
                m_v  = 1'b0;
            end
            if (wbw && wba != 0) m_regs[wba] = wbd;
            for (int r = 1; r < 32; r++) begin
                if (fl) m_pend[r] = 1'b0;
                else if (iv && id == r) m_pend[r] = 1'b1;
                else if (wbw && wba == r) m_pend[r] = 1'b0;
            end

            check("rnd rd_data1", rd_data1, m_d1);
            check("rnd rd_data2", rd_data2, m_d2);
            check("rnd rd_valid", 32'(rd_valid), 32'(m_v));
            check("rnd pending", pending, m_pend);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
